// File: rtl/data_axi_bridge_if.sv
// rtl/data_axi_bridge_if.sv - single-beat AXI4 read/write channel bundle between the data bridge and the crossbar
//
// Parameters: DATA_W (32/64), ADDR_W, ID_W.
// Modports:
//   master : the bridge side (drives AR/AW/W valids and payload, R/B ready)
//   slave  : the crossbar side (drives AR/AW/W ready, R/B valid and payload)
interface data_axi_bridge_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic [ID_W-1:0]     arid;
    logic [ADDR_W-1:0]   araddr;
    logic [7:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [3:0]          arcache;
    logic                arvalid;
    logic                arready;

    logic [ID_W-1:0]     rid;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    logic [ID_W-1:0]     awid;
    logic [ADDR_W-1:0]   awaddr;
    logic [7:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [3:0]          awcache;
    logic                awvalid;
    logic                awready;

    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_W-1:0]     bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arcache, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awcache, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/data_axi_bridge.sv
// rtl/data_axi_bridge.sv - core data-port load/store handshake to single-beat AXI4 bridge with posted write buffer
//
// Ports:
//   clock, reset         : clock, synchronous active-high reset
//   axi                  : data_axi_bridge_if.master, AR/R/AW/W/B channels
//   io_load_enable       : load request, held by the core until io_load_rValid
//   io_store_enable      : store request, held by the core until io_store_bValid
//   io_addr              : request address (shared by loads and stores)
//   io_store_sel/data    : byte strobes and store data
//   io_cached_trans      : cacheable attribute, selects AxCACHE 4'b1111 / 4'b0000
//   io_flush             : pipeline flush, squashes the in-flight load response
//   io_load_data         : last captured read data
//   io_load_rValid       : one-cycle load completion pulse
//   io_store_bValid      : one-cycle store acceptance pulse
// Optional feature macro DATA_AXI_PERF_CNT_EN adds perf_rd_cnt, perf_wr_cnt and
// perf_raw_stall saturating 32-bit counters.
module data_axi_bridge #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int ID_W       = 4,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                clock,
    input  logic                reset,
    data_axi_bridge_if.master   axi,
    input  logic                io_load_enable,
    input  logic                io_store_enable,
    input  logic [ADDR_W-1:0]   io_addr,
    input  logic [DATA_W/8-1:0] io_store_sel,
    input  logic [DATA_W-1:0]   io_store_data,
    input  logic                io_cached_trans,
    input  logic                io_flush,
    output logic [DATA_W-1:0]   io_load_data,
    output logic                io_load_rValid,
    output logic                io_store_bValid
`ifdef DATA_AXI_PERF_CNT_EN
    ,
    output logic [31:0]         perf_rd_cnt,
    output logic [31:0]         perf_wr_cnt,
    output logic [31:0]         perf_raw_stall
`endif
);

    localparam int IDX_W = $clog2(WBUF_DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [2:0] AXI_SIZE = 3'($clog2(DATA_W/8));

    typedef enum logic [1:0] {W_IDLE, W_SEND, W_RESP} w_state_t;
    typedef enum logic [1:0] {R_IDLE, R_AR, R_R} r_state_t;

    // ---------------------------------------------------------------
    // State
    // ---------------------------------------------------------------
    w_state_t            w_state_q, w_state_d;
    r_state_t            r_state_q, r_state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic                st_ack_q, st_ack_d;
    logic                ld_ack_q, ld_ack_d;
    logic                aw_done_q, aw_done_d;
    logic                w_done_q, w_done_d;
    logic                drop_q, drop_d;
    logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
    logic                rd_cached_q, rd_cached_d;
    logic [DATA_W-1:0]   load_data_q, load_data_d;

    // Write buffer storage; only the head entry is ever read.
    logic [ADDR_W-1:0]   wb_addr_q   [WBUF_DEPTH];
    logic [DATA_W-1:0]   wb_data_q   [WBUF_DEPTH];
    logic [DATA_W/8-1:0] wb_sel_q    [WBUF_DEPTH];
    logic                wb_cached_q [WBUF_DEPTH];

    logic                wb_empty, wb_full;
    logic                push, pop;
    logic [IDX_W-1:0]    head_idx, tail_idx;
    logic                arvalid_s, rready_s, awvalid_s, wvalid_s, bready_s;

    assign head_idx = rd_ptr_q[IDX_W-1:0];
    assign tail_idx = wr_ptr_q[IDX_W-1:0];
    assign wb_empty = (wr_ptr_q == rd_ptr_q);
    // The extra pointer MSB distinguishes a full buffer from an empty one.
    assign wb_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                      (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);

    // Fullness is the registered value, so a pop in the same cycle does not
    // open a slot for a push until the following cycle.
    assign push = io_store_enable && !wb_full && !st_ack_q;

    // ---------------------------------------------------------------
    // Store acceptance and buffer pointers
    // ---------------------------------------------------------------
    always_comb begin
        st_ack_d = push;
        wr_ptr_d = wr_ptr_q + PTR_W'(push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
    end

    // ---------------------------------------------------------------
    // Write drain FSM: one write outstanding, AW and W complete in any order
    // ---------------------------------------------------------------
    always_comb begin
        w_state_d = w_state_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        awvalid_s = 1'b0;
        wvalid_s  = 1'b0;
        bready_s  = 1'b0;
        pop       = 1'b0;
        case (w_state_q)
            W_IDLE: begin
                if (!wb_empty) begin
                    w_state_d = W_SEND;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end
            end
            W_SEND: begin
                awvalid_s = !aw_done_q;
                wvalid_s  = !w_done_q;
                if (awvalid_s && axi.awready) aw_done_d = 1'b1;
                if (wvalid_s && axi.wready)   w_done_d  = 1'b1;
                if (aw_done_d && w_done_d)    w_state_d = W_RESP;
            end
            W_RESP: begin
                bready_s = 1'b1;
                // The entry stays in the buffer until B so pending loads
                // remain ordered behind the write in flight.
                if (axi.bvalid) begin
                    pop       = 1'b1;
                    w_state_d = W_IDLE;
                end
            end
            default: w_state_d = W_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Read FSM: one read outstanding, flush only suppresses the pulse
    // ---------------------------------------------------------------
    always_comb begin
        r_state_d   = r_state_q;
        drop_d      = drop_q;
        rd_addr_d   = rd_addr_q;
        rd_cached_d = rd_cached_q;
        load_data_d = load_data_q;
        ld_ack_d    = 1'b0;
        arvalid_s   = 1'b0;
        rready_s    = 1'b0;
        case (r_state_q)
            R_IDLE: begin
                // ld_ack_q blocks the core's still-held enable in the
                // completion cycle from launching a duplicate read.
                if (io_load_enable && !io_store_enable && wb_empty &&
                    !io_flush && !ld_ack_q) begin
                    r_state_d   = R_AR;
                    rd_addr_d   = io_addr;
                    rd_cached_d = io_cached_trans;
                end
            end
            R_AR: begin
                arvalid_s = 1'b1;
                if (io_flush)     drop_d    = 1'b1;
                if (axi.arready)  r_state_d = R_R;
            end
            R_R: begin
                rready_s = 1'b1;
                if (io_flush) drop_d = 1'b1;
                if (axi.rvalid && axi.rlast) begin
                    load_data_d = axi.rdata;
                    ld_ack_d    = !drop_q && !io_flush;
                    drop_d      = 1'b0;
                    r_state_d   = R_IDLE;
                end
            end
            default: r_state_d = R_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // Registers
    // ---------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            w_state_q   <= W_IDLE;
            r_state_q   <= R_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            st_ack_q    <= 1'b0;
            ld_ack_q    <= 1'b0;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            drop_q      <= 1'b0;
            rd_addr_q   <= '0;
            rd_cached_q <= 1'b0;
            load_data_q <= '0;
        end else begin
            w_state_q   <= w_state_d;
            r_state_q   <= r_state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            st_ack_q    <= st_ack_d;
            ld_ack_q    <= ld_ack_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            drop_q      <= drop_d;
            rd_addr_q   <= rd_addr_d;
            rd_cached_q <= rd_cached_d;
            load_data_q <= load_data_d;
        end
    end

    // Buffer payload needs no reset: the pointers decide what is valid.
    always_ff @(posedge clock) begin
        if (push) begin
            wb_addr_q[tail_idx]   <= io_addr;
            wb_data_q[tail_idx]   <= io_store_data;
            wb_sel_q[tail_idx]    <= io_store_sel;
            wb_cached_q[tail_idx] <= io_cached_trans;
        end
    end

    // ---------------------------------------------------------------
    // AXI channel outputs
    // ---------------------------------------------------------------
    assign axi.arid    = ID_W'(0);
    assign axi.araddr  = rd_addr_q;
    assign axi.arlen   = 8'd0;
    assign axi.arsize  = AXI_SIZE;
    assign axi.arburst = 2'b01;
    assign axi.arcache = rd_cached_q ? 4'b1111 : 4'b0000;
    assign axi.arvalid = arvalid_s;
    assign axi.rready  = rready_s;

    assign axi.awid    = ID_W'(1);
    assign axi.awaddr  = wb_addr_q[head_idx];
    assign axi.awlen   = 8'd0;
    assign axi.awsize  = AXI_SIZE;
    assign axi.awburst = 2'b01;
    assign axi.awcache = wb_cached_q[head_idx] ? 4'b1111 : 4'b0000;
    assign axi.awvalid = awvalid_s;
    assign axi.wdata   = wb_data_q[head_idx];
    assign axi.wstrb   = wb_sel_q[head_idx];
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_s;
    assign axi.bready  = bready_s;

    assign io_load_data    = load_data_q;
    assign io_load_rValid  = ld_ack_q;
    assign io_store_bValid = st_ack_q;

    // IDs and response codes carry no information for this bridge.
    logic unused_axi_fields;
    assign unused_axi_fields = ^{axi.rid, axi.rresp, axi.bid, axi.bresp};

`ifdef DATA_AXI_PERF_CNT_EN
    logic [31:0] perf_rd_cnt_q, perf_rd_cnt_d;
    logic [31:0] perf_wr_cnt_q, perf_wr_cnt_d;
    logic [31:0] perf_raw_stall_q, perf_raw_stall_d;

    always_comb begin
        perf_rd_cnt_d    = perf_rd_cnt_q;
        perf_wr_cnt_d    = perf_wr_cnt_q;
        perf_raw_stall_d = perf_raw_stall_q;
        if (axi.rvalid && rready_s && (perf_rd_cnt_q != '1))
            perf_rd_cnt_d = perf_rd_cnt_q + 32'd1;
        if (axi.bvalid && bready_s && (perf_wr_cnt_q != '1))
            perf_wr_cnt_d = perf_wr_cnt_q + 32'd1;
        if ((r_state_q == R_IDLE) && io_load_enable && !wb_empty &&
            (perf_raw_stall_q != '1))
            perf_raw_stall_d = perf_raw_stall_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            perf_rd_cnt_q    <= '0;
            perf_wr_cnt_q    <= '0;
            perf_raw_stall_q <= '0;
        end else begin
            perf_rd_cnt_q    <= perf_rd_cnt_d;
            perf_wr_cnt_q    <= perf_wr_cnt_d;
            perf_raw_stall_q <= perf_raw_stall_d;
        end
    end

    assign perf_rd_cnt    = perf_rd_cnt_q;
    assign perf_wr_cnt    = perf_wr_cnt_q;
    assign perf_raw_stall = perf_raw_stall_q;
`endif

endmodule

// File: tb/tb_data_axi_bridge.sv
// tb/tb_data_axi_bridge.sv - directed self-checking bench for data_axi_bridge
module tb_data_axi_bridge;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        io_load_enable = 1'b0;
    logic        io_store_enable = 1'b0;
    logic [31:0] io_addr = '0;
    logic [3:0]  io_store_sel = '0;
    logic [31:0] io_store_data = '0;
    logic        io_cached_trans = 1'b0;
    logic        io_flush = 1'b0;
    logic [31:0] io_load_data;
    logic        io_load_rValid;
    logic        io_store_bValid;
`ifdef DATA_AXI_PERF_CNT_EN
    logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_raw_stall;
`endif

    data_axi_bridge_if #(.DATA_W(32), .ADDR_W(32), .ID_W(4)) axi ();

    data_axi_bridge #(.DATA_W(32), .ADDR_W(32), .ID_W(4), .WBUF_DEPTH(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .axi             (axi),
        .io_load_enable  (io_load_enable),
        .io_store_enable (io_store_enable),
        .io_addr         (io_addr),
        .io_store_sel    (io_store_sel),
        .io_store_data   (io_store_data),
        .io_cached_trans (io_cached_trans),
        .io_flush        (io_flush),
        .io_load_data    (io_load_data),
        .io_load_rValid  (io_load_rValid),
        .io_store_bValid (io_store_bValid)
`ifdef DATA_AXI_PERF_CNT_EN
        ,
        .perf_rd_cnt     (perf_rd_cnt),
        .perf_wr_cnt     (perf_wr_cnt),
        .perf_raw_stall  (perf_raw_stall)
`endif
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;
    int aw_hs = 0;
    int w_hs  = 0;
    int b_hs  = 0;

    // Handshakes are counted mid-cycle, where inputs and outputs are stable.
    always @(negedge clock) begin
        if (!reset) begin
            if (axi.awvalid && axi.awready) aw_hs <= aw_hs + 1;
            if (axi.wvalid && axi.wready)   w_hs  <= w_hs + 1;
            if (axi.bvalid && axi.bready)   b_hs  <= b_hs + 1;
        end
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_bvalid(input int budget, output bit seen);
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            seen = io_store_bValid;
        end
    endtask

    int  aw0, w0, b0, cnt;
    bit  seen;

    initial begin
        axi.arready = 0; axi.rid = '0; axi.rdata = '0; axi.rresp = '0;
        axi.rlast = 1;   axi.rvalid = 0;
        axi.awready = 0; axi.wready = 0;
        axi.bid = 4'd1;  axi.bresp = '0; axi.bvalid = 0;
        repeat (3) tick();
        reset = 1'b0;

        // ---- reset state
        chk("rst_arvalid", axi.arvalid, 0);
        chk("rst_awvalid", axi.awvalid, 0);
        chk("rst_wvalid",  axi.wvalid, 0);
        chk("rst_rready",  axi.rready, 0);
        chk("rst_bready",  axi.bready, 0);
        chk("rst_rvalid_o", io_load_rValid, 0);
        chk("rst_bvalid_o", io_store_bValid, 0);
        chk("rst_load_data", io_load_data, 0);

        // ---- basic load, 3-cycle latency
        io_load_enable = 1; io_addr = 32'h1000; io_cached_trans = 0;
        tick();
        chk("ld_arvalid", axi.arvalid, 1);
        chk("ld_araddr", axi.araddr, 32'h1000);
        chk("ld_arcache", axi.arcache, 0);
        chk("ld_arid", axi.arid, 0);
        chk("ld_arsize", axi.arsize, 2);
        chk("ld_arburst", axi.arburst, 1);
        axi.arready = 1;
        tick();
        axi.arready = 0;
        chk("ld_rready", axi.rready, 1);
        chk("ld_arvalid_off", axi.arvalid, 0);
        axi.rvalid = 1; axi.rdata = 32'hDEADBEEF;
        tick();
        axi.rvalid = 0;
        chk("ld_rvalid_c3", io_load_rValid, 1);
        chk("ld_data", io_load_data, 32'hDEADBEEF);
        io_load_enable = 0;
        tick();
        chk("ld_pulse_1cyc", io_load_rValid, 0);
        chk("ld_no_reissue", axi.arvalid, 0);

        // ---- posted store with AW/W stalled
        b0 = b_hs;
        io_store_enable = 1; io_addr = 32'h2004; io_store_sel = 4'hF;
        io_store_data = 32'h12345678; io_cached_trans = 0;
        tick();
        chk("st_bvalid_c1", io_store_bValid, 1);
        io_store_enable = 0;
        tick();
        chk("st_pulse_1cyc", io_store_bValid, 0);
        chk("st_awvalid", axi.awvalid, 1);
        chk("st_wvalid", axi.wvalid, 1);
        chk("st_awaddr", axi.awaddr, 32'h2004);
        chk("st_wdata", axi.wdata, 32'h12345678);
        chk("st_wstrb", axi.wstrb, 4'hF);
        chk("st_awid", axi.awid, 1);
        chk("st_awlen", axi.awlen, 0);
        chk("st_wlast", axi.wlast, 1);
        cnt = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (axi.awvalid && axi.wvalid) cnt++;
        end
        chk("st_valid_held", cnt, 8);
        axi.awready = 1; axi.wready = 1;
        tick();
        axi.awready = 0; axi.wready = 0;
        chk("st_aw_dropped", axi.awvalid, 0);
        chk("st_w_dropped", axi.wvalid, 0);
        chk("st_bready", axi.bready, 1);
        tick(); tick();
        chk("st_bready_held", axi.bready, 1);
        axi.bvalid = 1;
        tick();
        axi.bvalid = 0;
        chk("st_bready_off", axi.bready, 0);
        chk("st_one_b", b_hs - b0, 1);

        // ---- full buffer: B stalled, 5 back-to-back stores
        aw0 = aw_hs; b0 = b_hs;
        axi.awready = 1; axi.wready = 1; axi.bvalid = 0;
        io_store_sel = 4'hF; io_store_enable = 1;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            io_addr = 32'h4000 + 32'(i * 4); io_store_data = 32'hA000 + 32'(i);
            wait_bvalid(6, seen);
            if (seen) cnt++;
        end
        chk("full_4_pulses", cnt, 4);
        io_addr = 32'h4010; io_store_data = 32'hA004;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (io_store_bValid) cnt++;
        end
        chk("full_5th_stalled", cnt, 0);
        axi.bvalid = 1;
        tick();
        axi.bvalid = 0;
        wait_bvalid(6, seen);
        chk("full_5th_accepted", seen, 1);
        io_store_enable = 0;
        axi.bvalid = 1;
        repeat (24) tick();
        axi.bvalid = 0;
        axi.awready = 0; axi.wready = 0;
        tick();
        chk("full_aw_count", aw_hs - aw0, 5);
        chk("full_b_count", b_hs - b0, 5);

        // ---- read after write
        axi.awready = 1; axi.wready = 1;
        io_store_enable = 1; io_addr = 32'h3000; io_store_data = 32'h55; io_store_sel = 4'h1;
        tick();
        chk("raw_st_bvalid", io_store_bValid, 1);
        io_store_enable = 0; io_load_enable = 1; io_addr = 32'h3000;
        cnt = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (axi.arvalid) cnt++;
        end
        chk("raw_ar_blocked", cnt, 0);
        axi.bvalid = 1;
        tick();
        axi.bvalid = 0; axi.awready = 0; axi.wready = 0;
        chk("raw_ar_still_0", axi.arvalid, 0);
        tick();
        chk("raw_arvalid", axi.arvalid, 1);
        chk("raw_araddr", axi.araddr, 32'h3000);
        axi.arready = 1;
        tick();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'hCAFEF00D;
        tick();
        axi.rvalid = 0; io_load_enable = 0;
        chk("raw_rvalid", io_load_rValid, 1);
        chk("raw_data", io_load_data, 32'hCAFEF00D);
        tick();

        // ---- flush while in R_R
        io_load_enable = 1; io_addr = 32'h5000; io_cached_trans = 1;
        tick();
        chk("fl_arcache", axi.arcache, 4'hF);
        axi.arready = 1;
        tick();
        axi.arready = 0;
        io_flush = 1; io_load_enable = 0; io_cached_trans = 0;
        chk("fl_rready", axi.rready, 1);
        cnt = 0;
        tick();
        io_flush = 0;
        if (io_load_rValid) cnt++;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (io_load_rValid) cnt++;
        end
        tick();
        axi.rvalid = 1; axi.rdata = 32'h0BAD0BAD;
        chk("fl_rready_late", axi.rready, 1);
        tick();
        axi.rvalid = 0;
        if (io_load_rValid) cnt++;
        tick();
        if (io_load_rValid) cnt++;
        chk("fl_no_pulse", cnt, 0);
        chk("fl_rready_off", axi.rready, 0);
        io_load_enable = 1; io_addr = 32'h6000;
        tick();
        chk("fl_next_arvalid", axi.arvalid, 1);
        chk("fl_next_araddr", axi.araddr, 32'h6000);
        chk("fl_next_arcache", axi.arcache, 0);
        axi.arready = 1;
        tick();
        axi.arready = 0; axi.rvalid = 1; axi.rdata = 32'h0000600D;
        tick();
        axi.rvalid = 0; io_load_enable = 0;
        chk("fl_next_rvalid", io_load_rValid, 1);
        chk("fl_next_data", io_load_data, 32'h0000600D);
        tick();

        // ---- AW/W skew: W completes first
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs;
        io_store_enable = 1; io_addr = 32'h7000; io_store_data = 32'hA5A5A5A5;
        io_store_sel = 4'h3; io_cached_trans = 1;
        tick();
        io_store_enable = 0;
        tick();
        chk("sk_both_valid", {axi.awvalid, axi.wvalid}, 2'b11);
        chk("sk_awcache", axi.awcache, 4'hF);
        chk("sk_wstrb", axi.wstrb, 4'h3);
        axi.wready = 1;
        tick();
        axi.wready = 0;
        chk("sk_w_dropped", {axi.awvalid, axi.wvalid}, 2'b10);
        tick(); tick();
        chk("sk_aw_persists", {axi.awvalid, axi.wvalid}, 2'b10);
        axi.awready = 1;
        tick();
        axi.awready = 0;
        chk("sk_resp", {axi.awvalid, axi.wvalid, axi.bready}, 3'b001);
        axi.bvalid = 1;
        tick();
        axi.bvalid = 0;
        repeat (3) tick();
        chk("sk_idle", {axi.awvalid, axi.wvalid, axi.bready}, 3'b000);
        chk("sk_aw_once", aw_hs - aw0, 1);
        chk("sk_w_once", w_hs - w0, 1);
        chk("sk_b_once", b_hs - b0, 1);

        // ---- reset mid-transaction
        io_load_enable = 1; io_addr = 32'h8000;
        tick();
        chk("mr_arvalid", axi.arvalid, 1);
        io_load_enable = 0; reset = 1;
        tick();
        reset = 0;
        chk("mr_arvalid_cleared", axi.arvalid, 0);
        chk("mr_rready_cleared", axi.rready, 0);
        chk("mr_load_data", io_load_data, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
